// File: rtl/mx_block_encoder.sv
// Streaming MX block encoder: gathers k signed elements, derives a shared scale
// from the widest element, and emits the block narrowed to bit_width with that scale.
module mx_block_encoder #(
    parameter int k         = 32,
    parameter int in_width  = 16,
    parameter int bit_width = 8
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic signed [in_width-1:0]        i_data,
    input  logic        [7:0]                 i_scale,
    input  logic                              i_valid,
    output logic                              o_in_ready,
    output logic        [k-1:0][bit_width-1:0] o_elem,
    output logic        [7:0]                 o_scale,
    output logic                              o_sat,
    output logic                              o_valid,
    input  logic                              i_out_ready
);

    localparam int CW = $clog2(k);
    localparam int WW = $clog2(in_width + 1);

    localparam logic [1:0] FILL = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] EMIT = 2'd2;

    localparam logic signed [in_width:0] MAX_V = (in_width+1)'(2**(bit_width-1) - 1);
    localparam logic signed [in_width:0] MIN_V = -(in_width+1)'(2**(bit_width-1));

    // Two's-complement width of v equals that of ~v, so only non-negative magnitudes are scanned.
    function automatic logic [WW-1:0] elem_width(input logic signed [in_width-1:0] v);
        logic [in_width-1:0] u;
        logic [WW-1:0]       w;
        u = v[in_width-1] ? ~v : v;
        w = WW'(1);
        for (int b = 0; b < in_width; b++) begin
            if (u[b]) w = WW'(b + 2);
        end
        return w;
    endfunction

    // One guard bit above in_width keeps the round-half-up addend from wrapping at full scale.
    function automatic logic [bit_width-1:0] narrow(input logic signed [in_width-1:0] v,
                                                    input logic [WW-1:0] s);
        logic signed [in_width:0] ext;
        logic signed [in_width:0] half;
        logic signed [in_width:0] rnd;
        ext  = {v[in_width-1], v};
        half = '0;
        if (s != '0) half[s - WW'(1)] = 1'b1;
        rnd = (ext + half) >>> s;
        if (rnd > MAX_V) rnd = MAX_V;
        else if (rnd < MIN_V) rnd = MIN_V;
        return rnd[bit_width-1:0];
    endfunction

    logic [1:0]                       state_q, state_d;
    logic [CW-1:0]                    count_q, count_d;
    logic [WW-1:0]                    wmax_q, wmax_d;
    logic [7:0]                       scale_in_q, scale_in_d;
    logic signed [in_width-1:0]       buf_q [k];
    logic signed [in_width-1:0]       buf_d [k];
    logic [k-1:0][bit_width-1:0]      elem_q, elem_d;
    logic [7:0]                       scale_q, scale_d;
    logic                             sat_q, sat_d;

    logic                             accept;
    logic [WW-1:0]                    w_new;
    logic [WW-1:0]                    shift;
    logic [8:0]                       scale_sum;

    assign o_in_ready = (state_q == FILL) & ~i_rst;
    assign o_valid    = (state_q == EMIT);
    assign o_elem     = elem_q;
    assign o_scale    = scale_q;
    assign o_sat      = sat_q;

    assign accept    = i_valid & o_in_ready;
    assign w_new     = elem_width(i_data);
    assign shift     = (wmax_q > WW'(bit_width)) ? (wmax_q - WW'(bit_width)) : '0;
    assign scale_sum = {1'b0, scale_in_q} + 9'(shift);

    always_comb begin
        // NOTE: every next-state variable takes its current value first so no path infers a latch.
        state_d    = state_q;
        count_d    = count_q;
        wmax_d     = wmax_q;
        scale_in_d = scale_in_q;
        buf_d      = buf_q;
        elem_d     = elem_q;
        scale_d    = scale_q;
        sat_d      = sat_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    buf_d[count_q] = i_data;
                    if (count_q == '0) scale_in_d = i_scale;
                    if (w_new > wmax_q) wmax_d = w_new;
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(k - 1)) state_d = CALC;
                end
            end
            CALC: begin
                for (int n = 0; n < k; n++) elem_d[n] = narrow(buf_q[n], shift);
                scale_d = scale_sum[8] ? 8'hff : scale_sum[7:0];
                sat_d   = scale_sum[8];
                state_d = EMIT;
            end
            EMIT: begin
                if (i_out_ready) begin
                    state_d = FILL;
                    wmax_d  = '0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= FILL;
            count_q    <= '0;
            wmax_q     <= '0;
            scale_in_q <= '0;
            elem_q     <= '0;
            scale_q    <= '0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wmax_q     <= wmax_d;
            scale_in_q <= scale_in_d;
            elem_q     <= elem_d;
            scale_q    <= scale_d;
            sat_q      <= sat_d;
        end
    end

    // NOTE: the element buffer is not reset; the cleared count makes stale entries unreachable.
    always_ff @(posedge i_clk) begin
        buf_q <= buf_d;
    end

endmodule

// File: tb/tb_mx_block_encoder.sv
// Self-checking bench for mx_block_encoder: table-driven blocks plus backpressure,
// gap and reset sequences, scored against a behavioural model through a queue.
module tb_mx_block_encoder;

    localparam int K  = 32;
    localparam int IW = 16;
    localparam int BW = 8;

    logic                        i_clk = 1'b0;
    logic                        i_rst = 1'b1;
    logic signed [IW-1:0]        i_data = '0;
    logic [7:0]                  i_scale = '0;
    logic                        i_valid = 1'b0;
    logic                        o_in_ready;
    logic [K-1:0][BW-1:0]        o_elem;
    logic [7:0]                  o_scale;
    logic                        o_sat;
    logic                        o_valid;
    logic                        i_out_ready = 1'b0;

    mx_block_encoder #(.k(K), .in_width(IW), .bit_width(BW)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_data      (i_data),
        .i_scale     (i_scale),
        .i_valid     (i_valid),
        .o_in_ready  (o_in_ready),
        .o_elem      (o_elem),
        .o_scale     (o_scale),
        .o_sat       (o_sat),
        .o_valid     (o_valid),
        .i_out_ready (i_out_ready)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [K-1:0][BW-1:0] e;
        logic [7:0]           scale;
        logic                 sat;
    } exp_t;

    typedef struct {
        int pat;
        int sc;
        int exp_scale;
        int exp_sat;
        int e0;
        int e1;
        int e2;
    } vec_t;

    exp_t exp_q[$];
    int   cur[K];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: width by range search, floor-shift rounding in 32-bit integers.
    function automatic exp_t model(input int sc);
        exp_t r;
        int   wm = 0;
        int   s;
        int   t;
        for (int i = 0; i < K; i++) begin
            int n = 1;
            while (!(cur[i] >= -(1 << (n-1)) && cur[i] <= (1 << (n-1)) - 1)) n++;
            if (n > wm) wm = n;
        end
        s = (wm > BW) ? wm - BW : 0;
        for (int i = 0; i < K; i++) begin
            t = cur[i] + ((s > 0) ? (1 << (s-1)) : 0);
            t = t >>> s;
            if (t > 127) t = 127;
            if (t < -128) t = -128;
            r.e[i] = t[7:0];
        end
        if (sc + s > 255) begin
            r.scale = 8'd255;
            r.sat   = 1'b1;
        end else begin
            r.scale = 8'(sc + s);
            r.sat   = 1'b0;
        end
        return r;
    endfunction

    task automatic fill_pattern(input int pat);
        for (int i = 0; i < K; i++) begin
            case (pat)
                0: cur[i] = i;
                1: cur[i] = (i == 0) ? 1000 : ((i % 2 == 1) ? 12 : -13);
                default: cur[i] = (i == 0) ? 32767 : ((i == 1) ? -32768 : 0);
            endcase
        end
    endtask

    task automatic send_elem(input int v, input int sc);
        int guard = 0;
        @(negedge i_clk);
        while (!o_in_ready && guard < 100) begin
            @(negedge i_clk);
            guard++;
        end
        if (!o_in_ready) check("in_ready_timeout", 0, 1);
        i_data  = IW'(v);
        i_scale = 8'(sc);
        i_valid = 1'b1;
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_block(input int sc, input bit gaps, input bit push);
        if (push) exp_q.push_back(model(sc));
        for (int i = 0; i < K; i++) begin
            if (gaps) begin
                int g = $urandom_range(0, 2);
                i_valid = 1'b0;
                i_data  = IW'($urandom);
                i_scale = 8'($urandom);
                repeat (g) @(posedge i_clk);
                #1;
            end
            send_elem(cur[i], (i == 0 || !gaps) ? sc : int'($urandom_range(0, 255)));
        end
        i_valid = 1'b0;
    endtask

    task automatic recv_block(input int hold);
        int                   guard = 0;
        exp_t                 e;
        logic [K-1:0][BW-1:0] snap;
        logic [7:0]           snap_s;
        logic                 snap_sat;
        while (!o_valid && guard < 200) begin
            @(negedge i_clk);
            guard++;
        end
        if (!o_valid) begin
            check("valid_timeout", 0, 1);
            return;
        end
        snap     = o_elem;
        snap_s   = o_scale;
        snap_sat = o_sat;
        i_out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge i_clk);
            check("hold_stable", int'(o_elem == snap && o_scale == snap_s && o_sat == snap_sat), 1);
            check("hold_valid", int'(o_valid), 1);
            check("hold_in_ready", int'(o_in_ready), 0);
        end
        if (exp_q.size() == 0) begin
            check("queue_empty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            for (int n = 0; n < K; n++)
                check($sformatf("elem%0d", n), int'($signed(o_elem[n])), int'($signed(e.e[n])));
            check("scale", int'(o_scale), int'(e.scale));
            check("sat", int'(o_sat), int'(e.sat));
        end
        @(negedge i_clk);
        i_out_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_out_ready = 1'b0;
        @(negedge i_clk);
        check("valid_drop", int'(o_valid), 0);
        check("in_ready_back", int'(o_in_ready), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        vecs[0] = '{pat: 0, sc: 10,  exp_scale: 10,  exp_sat: 0, e0: 0,   e1: 1,    e2: 2};
        vecs[1] = '{pat: 1, sc: 30,  exp_scale: 33,  exp_sat: 0, e0: 125, e1: 2,    e2: -2};
        vecs[2] = '{pat: 2, sc: 5,   exp_scale: 13,  exp_sat: 0, e0: 127, e1: -128, e2: 0};
        vecs[3] = '{pat: 2, sc: 250, exp_scale: 255, exp_sat: 1, e0: 127, e1: -128, e2: 0};
        vecs[4] = '{pat: 2, sc: 247, exp_scale: 255, exp_sat: 0, e0: 127, e1: -128, e2: 0};
        vecs[5] = '{pat: 0, sc: 0,   exp_scale: 0,   exp_sat: 0, e0: 0,   e1: 1,    e2: 2};

        repeat (2) @(negedge i_clk);
        check("rst_in_ready", int'(o_in_ready), 0);
        i_rst = 1'b0;
        @(negedge i_clk);
        check("rst_valid", int'(o_valid), 0);
        check("rst_elem_zero", int'(o_elem == '0), 1);
        check("rst_scale", int'(o_scale), 0);
        check("rst_sat", int'(o_sat), 0);
        check("rst_in_ready_fill", int'(o_in_ready), 1);

        // Table-driven blocks; the first one also checks CALC/EMIT timing.
        for (int v = 0; v < 6; v++) begin
            fill_pattern(vecs[v].pat);
            send_block(vecs[v].sc, 1'b0, 1'b1);
            if (v == 0) begin
                @(negedge i_clk);
                check("calc_valid_low", int'(o_valid), 0);
                check("calc_in_ready_low", int'(o_in_ready), 0);
                @(negedge i_clk);
                check("valid_rise", int'(o_valid), 1);
            end
            recv_block(0);
            check($sformatf("tbl%0d_scale", v), int'(o_scale), vecs[v].exp_scale);
            check($sformatf("tbl%0d_sat", v), int'(o_sat), vecs[v].exp_sat);
            check($sformatf("tbl%0d_e0", v), int'($signed(o_elem[0])), vecs[v].e0);
            check($sformatf("tbl%0d_e1", v), int'($signed(o_elem[1])), vecs[v].e1);
            check($sformatf("tbl%0d_e2", v), int'($signed(o_elem[2])), vecs[v].e2);
        end

        // Three back-to-back random blocks with input gaps and output backpressure.
        for (int b = 0; b < 3; b++) begin
            int mag = 1 << (6 + 3*b);
            for (int i = 0; i < K; i++) cur[i] = int'($urandom_range(0, 2*mag - 1)) - mag;
            send_block(int'($urandom_range(0, 200)), 1'b1, 1'b1);
            recv_block(5);
        end

        // Reset mid-fill: only the post-reset block may appear.
        for (int i = 0; i < 10; i++) send_elem(100 + i, 77);
        i_valid = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        check("midfill_rst_in_ready", int'(o_in_ready), 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        fill_pattern(0);
        send_block(20, 1'b0, 1'b1);
        recv_block(0);

        // Reset while a block is held.
        fill_pattern(1);
        send_block(40, 1'b0, 1'b0);
        begin
            int guard = 0;
            while (!o_valid && guard < 50) begin
                @(negedge i_clk);
                guard++;
            end
            check("emit_reached", int'(o_valid), 1);
        end
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        check("emit_rst_valid", int'(o_valid), 0);
        check("emit_rst_elem_zero", int'(o_elem == '0), 1);
        check("emit_rst_scale", int'(o_scale), 0);
        check("emit_rst_sat", int'(o_sat), 0);
        fill_pattern(2);
        send_block(100, 1'b0, 1'b1);
        recv_block(0);

        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
